spi_fsm: RTL and testbench

Transaction controller for the SPI memory slave. It consumes the debounced chip-select level and the one-cycle serial-clock rising-edge pulse produced by the input conditioners, counts bits, and sequences the address latch, the shift-register parallel load, the data-memory write and the MISO output buffer. It sits between the input conditioners and the shift register / data memory / address latch datapath.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_fsm_if.sv | 37 +++
 rtl/sclk_counter.sv | 34 +++
 rtl/spi_fsm.sv | 123 ++++++++++++
 tb/tb_spi_fsm.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI memory-slave transaction controller.
package spi_pkg;

    localparam int unsigned AddrBitsDef = 7;
    localparam int unsigned DataBitsDef = 8;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StGetAddr    = 3'd1,
        StLatch      = 3'd2,
        StReadLoad   = 3'd3,
        StReadShift  = 3'd4,
        StWriteShift = 3'd5,
        StWriteMem   = 3'd6,
        StDone       = 3'd7
    } spi_state_e;

    // Wide enough to hold the larger of (address + R/W) and data bit counts.
    function automatic int unsigned cnt_width(input int unsigned addr_bits,
                                              input int unsigned data_bits);
        int unsigned max_v;
        max_v = (addr_bits + 1 > data_bits) ? addr_bits + 1 : data_bits;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/spi_fsm_if.sv
// Control/status bundle between the SPI transaction FSM and its conditioners/datapath.
// Carries the optional err flag when SPI_FSM_ERR_EN is defined.
interface spi_fsm_if;

    logic cs_cond;
    logic sclk_pos;
    logic rw_bit;
    logic addr_we;
    logic sr_we;
    logic dm_we;
    logic miso_buff;
    logic busy;
`ifdef SPI_FSM_ERR_EN
    logic err;

    modport master (
        input  cs_cond, sclk_pos, rw_bit,
        output addr_we, sr_we, dm_we, miso_buff, busy, err
    );

    modport slave (
        output cs_cond, sclk_pos, rw_bit,
        input  addr_we, sr_we, dm_we, miso_buff, busy, err
    );
`else
    modport master (
        input  cs_cond, sclk_pos, rw_bit,
        output addr_we, sr_we, dm_we, miso_buff, busy
    );

    modport slave (
        output cs_cond, sclk_pos, rw_bit,
        input  addr_we, sr_we, dm_we, miso_buff, busy
    );
`endif

endinterface

// File: rtl/sclk_counter.sv
// Clearable, enable-driven bit counter; hit_o flags the enable that reaches term_i.
module sclk_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic             hit_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = en_i & ((cnt_q + Width'(1)) == term_i);

endmodule

// File: rtl/spi_fsm.sv
// SPI memory-slave transaction controller: counts SCLK edges and sequences address latch,
// shift-register load, memory write and MISO enable. SPI_FSM_ERR_EN adds a sticky abort flag.
module spi_fsm
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_BITS = AddrBitsDef,
    parameter int unsigned DATA_BITS = DataBitsDef
) (
    input logic       clk,
    input logic       rst_n,
    spi_fsm_if.master spi_io
);

    localparam int unsigned     CntW     = cnt_width(ADDR_BITS, DATA_BITS);
    localparam logic [CntW-1:0] AddrTerm = CntW'(ADDR_BITS + 1);
    localparam logic [CntW-1:0] DataTerm = CntW'(DATA_BITS);

    spi_state_e      state_q, state_d;
    logic            cs_prev_q, cs_prev_d;
    logic            armed_q, armed_d;
    logic            cs_fall;
    logic            cnt_en, cnt_clr, cnt_hit;
    logic [CntW-1:0] cnt_term;

    // armed_q blocks a start until cs has been seen high since reset, so a
    // reset released with cs already low does not look like a falling edge.
    assign cs_fall = armed_q & cs_prev_q & ~spi_io.cs_cond;

    always_comb begin
        cs_prev_d = spi_io.cs_cond;
        armed_d   = armed_q | spi_io.cs_cond;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev_q <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            cs_prev_q <= cs_prev_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        cnt_en   = spi_io.sclk_pos &
                   (state_q inside {StGetAddr, StReadShift, StWriteShift});
        cnt_term = (state_q == StGetAddr) ? AddrTerm : DataTerm;
        cnt_clr  = (state_d != state_q);
    end

    sclk_counter #(
        .Width (CntW)
    ) u_sclk_counter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .hit_o  (cnt_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:       if (cs_fall) state_d = StGetAddr;
            StGetAddr:    if (cnt_hit) state_d = StLatch;
            StLatch:      state_d = spi_io.rw_bit ? StReadLoad : StWriteShift;
            StReadLoad:   state_d = StReadShift;
            StReadShift:  if (cnt_hit) state_d = StDone;
            StWriteShift: if (cnt_hit) state_d = StWriteMem;
            StWriteMem:   state_d = StDone;
            StDone:       state_d = StDone;
            default:      state_d = StIdle;
        endcase
        // Deselect overrides any same-cycle edge or count match.
        if (state_q != StIdle && spi_io.cs_cond) begin
            state_d = StIdle;
        end
    end

`ifdef SPI_FSM_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (cs_fall) begin
            err_d = 1'b0;
        end else if (spi_io.cs_cond && (state_q inside {StGetAddr, StLatch, StReadLoad,
                                                       StReadShift, StWriteShift,
                                                       StWriteMem})) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    always_comb begin
        spi_io.addr_we   = (state_q == StLatch);
        spi_io.sr_we     = (state_q == StReadLoad);
        spi_io.dm_we     = (state_q == StWriteMem);
        spi_io.miso_buff = (state_q == StReadShift);
        spi_io.busy      = (state_q != StIdle);
`ifdef SPI_FSM_ERR_EN
        spi_io.err       = err_q;
`endif
    end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed self-checking bench for spi_fsm (7 address bits, 8 data bits).
// Covers the err flag too when SPI_FSM_ERR_EN is defined.
module tb_spi_fsm;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_fsm_if spi_bus ();

    spi_fsm #(
        .ADDR_BITS (7),
        .DATA_BITS (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .spi_io (spi_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse/cycle counters sampled on the falling edge.
    int cnt_addr_we    = 0;
    int cnt_sr_we      = 0;
    int cnt_dm_we      = 0;
    int cnt_miso       = 0;
    int cnt_miso_sclk  = 0;
    int base_addr_we, base_sr_we, base_dm_we, base_miso, base_miso_sclk;

    always @(negedge clk) begin
        if (spi_bus.addr_we)   cnt_addr_we <= cnt_addr_we + 1;
        if (spi_bus.sr_we)     cnt_sr_we   <= cnt_sr_we + 1;
        if (spi_bus.dm_we)     cnt_dm_we   <= cnt_dm_we + 1;
        if (spi_bus.miso_buff) cnt_miso    <= cnt_miso + 1;
        if (spi_bus.miso_buff && spi_bus.sclk_pos) cnt_miso_sclk <= cnt_miso_sclk + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'b%0b required 'b%0b", tag, got, exp);
        end
    endtask

    // {addr_we, sr_we, dm_we, miso_buff, busy}
    function automatic logic [31:0] outs();
        return 32'({spi_bus.addr_we, spi_bus.sr_we, spi_bus.dm_we,
                    spi_bus.miso_buff, spi_bus.busy});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sclk_edge();
        spi_bus.sclk_pos = 1'b1;
        tick();
        spi_bus.sclk_pos = 1'b0;
    endtask

    task automatic gap();
        repeat (3) tick();
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            sclk_edge();
            gap();
        end
    endtask

    task automatic snap();
        base_addr_we   = cnt_addr_we;
        base_sr_we     = cnt_sr_we;
        base_dm_we     = cnt_dm_we;
        base_miso      = cnt_miso;
        base_miso_sclk = cnt_miso_sclk;
    endtask

    initial begin
        rst_n            = 1'b0;
        spi_bus.cs_cond  = 1'b1;
        spi_bus.sclk_pos = 1'b0;
        spi_bus.rw_bit   = 1'b0;
        repeat (2) tick();
        check("reset outs", outs(), 'b00000);
`ifdef SPI_FSM_ERR_EN
        check("reset err", 32'(spi_bus.err), 0);
`endif
        rst_n = 1'b1;
        tick();
        check("idle after reset", outs(), 'b00000);

        // Write: address 0x2A + R/W=0, data 0xC3 (serial data is outside this block).
        snap();
        spi_bus.rw_bit  = 1'b0;
        spi_bus.cs_cond = 1'b0;
        tick();
        check("wr start", outs(), 'b00001);
        pulses(7);
        check("wr before 8th edge", outs(), 'b00001);
        sclk_edge();
        check("wr latch", outs(), 'b10001);
        tick();
        check("wr shift", outs(), 'b00001);
        repeat (2) tick();
        pulses(7);
        check("wr before 16th edge", outs(), 'b00001);
        sclk_edge();
        check("wr mem", outs(), 'b00101);
        tick();
        check("wr done", outs(), 'b00001);
        gap();
        sclk_edge();
        check("done ignores sclk", outs(), 'b00001);
        gap();
        spi_bus.cs_cond = 1'b1;
        tick();
        check("wr end idle", outs(), 'b00000);
        check("wr addr_we pulses", cnt_addr_we - base_addr_we, 1);
        check("wr dm_we pulses", cnt_dm_we - base_dm_we, 1);
        check("wr sr_we pulses", cnt_sr_we - base_sr_we, 0);
        check("wr miso cycles", cnt_miso - base_miso, 0);
`ifdef SPI_FSM_ERR_EN
        check("wr err", 32'(spi_bus.err), 0);
`endif

        // Read: address 0x05 + R/W=1.
        snap();
        spi_bus.rw_bit  = 1'b1;
        spi_bus.cs_cond = 1'b0;
        tick();
        check("rd start", outs(), 'b00001);
        pulses(7);
        sclk_edge();
        check("rd latch", outs(), 'b10001);
        tick();
        check("rd load", outs(), 'b01001);
        tick();
        check("rd shift", outs(), 'b00011);
        tick();
        pulses(7);
        check("rd before 8th data edge", outs(), 'b00011);
        sclk_edge();
        check("rd done", outs(), 'b00001);
        repeat (6) tick();
        check("rd hold done", outs(), 'b00001);
        spi_bus.cs_cond = 1'b1;
        tick();
        check("rd end idle", outs(), 'b00000);
        check("rd addr_we pulses", cnt_addr_we - base_addr_we, 1);
        check("rd sr_we pulses", cnt_sr_we - base_sr_we, 1);
        check("rd dm_we pulses", cnt_dm_we - base_dm_we, 0);
        check("rd miso sclk edges", cnt_miso_sclk - base_miso_sclk, 8);

        // Write aborted after 11 edges.
        snap();
        spi_bus.rw_bit  = 1'b0;
        spi_bus.cs_cond = 1'b0;
        tick();
        pulses(8);
        check("ab write shift", outs(), 'b00001);
        pulses(3);
        spi_bus.cs_cond = 1'b1;
        tick();
        check("ab idle", outs(), 'b00000);
        tick();
        check("ab dm_we pulses", cnt_dm_we - base_dm_we, 0);
`ifdef SPI_FSM_ERR_EN
        check("ab err set", 32'(spi_bus.err), 1);
`endif

        // Deselect and 8th address edge in the same cycle.
        snap();
        spi_bus.cs_cond = 1'b0;
        tick();
        check("pri start", outs(), 'b00001);
`ifdef SPI_FSM_ERR_EN
        check("pri err cleared", 32'(spi_bus.err), 0);
`endif
        pulses(7);
        spi_bus.sclk_pos = 1'b1;
        spi_bus.cs_cond  = 1'b1;
        tick();
        spi_bus.sclk_pos = 1'b0;
        check("pri idle", outs(), 'b00000);
        tick();
        check("pri addr_we pulses", cnt_addr_we - base_addr_we, 0);
`ifdef SPI_FSM_ERR_EN
        check("pri err set", 32'(spi_bus.err), 1);
`endif

        // Asynchronous reset mid READ_SHIFT, released with cs still low.
        spi_bus.rw_bit  = 1'b1;
        spi_bus.cs_cond = 1'b0;
        tick();
        pulses(8);
        check("rst pre shift", outs(), 'b00011);
        pulses(3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset drop", outs(), 'b00000);
`ifdef SPI_FSM_ERR_EN
        check("async reset err", 32'(spi_bus.err), 0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("cs low after reset stays idle", outs(), 'b00000);
        spi_bus.cs_cond = 1'b1;
        tick();
        check("cs high idle", outs(), 'b00000);
        spi_bus.cs_cond = 1'b0;
        tick();
        check("start after cs fall", outs(), 'b00001);
        spi_bus.cs_cond = 1'b1;
        tick();
        check("final idle", outs(), 'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
